load_program_fsm: RTL and testbench

//  Receive side of the debug UART link: collects bytes from the UART receiver, assembles

---
 rtl/load_program_fsm_pkg.sv | 17 +
 rtl/load_program_fsm_if.sv | 32 +++
 rtl/load_program_fsm_word_assembler.sv | 61 ++++++
 rtl/load_program_fsm.sv | 110 +++++++++++
 tb/tb_load_program_fsm.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/load_program_fsm_pkg.sv
// Shared constants and state encoding for the program loader.
package load_program_fsm_pkg;

  localparam int unsigned DEF_UART_BITS        = 8;
  localparam int unsigned DEF_INSTRUCTION_BITS = 32;
  localparam int unsigned DEF_PC_BITS          = 10;
  localparam int unsigned OPCODE_BITS          = 6;

  localparam logic [OPCODE_BITS-1:0] HALT_OPCODE = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/load_program_fsm_if.sv
// UART-byte input and instruction-memory write port of the program loader.
interface load_program_fsm_if
  import load_program_fsm_pkg::*;
#(
  parameter int unsigned UART_BITS        = DEF_UART_BITS,
  parameter int unsigned INSTRUCTION_BITS = DEF_INSTRUCTION_BITS,
  parameter int unsigned PC_BITS          = DEF_PC_BITS
);

  logic                        i_start;
  logic                        i_rx_done;
  logic [UART_BITS-1:0]        i_rx_data;
  logic                        o_inst_write;
  logic [PC_BITS-1:0]          o_inst_address;
  logic [INSTRUCTION_BITS-1:0] o_inst_data;
  logic                        o_busy;
  logic                        o_done;
  logic                        o_overflow;

  // Loader side
  modport slave (
    input  i_start, i_rx_done, i_rx_data,
    output o_inst_write, o_inst_address, o_inst_data, o_busy, o_done, o_overflow
  );

  // Stimulus / system side
  modport master (
    output i_start, i_rx_done, i_rx_data,
    input  o_inst_write, o_inst_address, o_inst_data, o_busy, o_done, o_overflow
  );

endinterface

// File: rtl/load_program_fsm_word_assembler.sv
// Shifts received bytes MSB-first into a word and pulses word_valid for one
// cycle after the last byte of each word has been taken.
module load_program_fsm_word_assembler
  import load_program_fsm_pkg::*;
#(
  parameter int unsigned UART_BITS        = DEF_UART_BITS,
  parameter int unsigned INSTRUCTION_BITS = DEF_INSTRUCTION_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        byte_valid,
  input  logic [UART_BITS-1:0]        byte_data,
  output logic                        word_valid,
  output logic [INSTRUCTION_BITS-1:0] word
);

  localparam int unsigned BYTES_PER_WORD = INSTRUCTION_BITS / UART_BITS;
  localparam int unsigned CNT_BITS       = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(BYTES_PER_WORD - 1);

  logic [CNT_BITS-1:0]         cnt_q, cnt_d;
  logic [INSTRUCTION_BITS-1:0] shift_q, shift_d;
  logic                        valid_q, valid_d;

  // Next shift/count: clear wins, otherwise shift in a byte and wrap the count
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      shift_d = INSTRUCTION_BITS'({shift_q, byte_data});
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  // Assembly registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid = valid_q;
  assign word       = shift_q;

endmodule

// File: rtl/load_program_fsm.sv
// Loads a program received over UART into instruction memory, word by word
// from address 0, until a HALT word is written or memory is full.
module load_program_fsm
  import load_program_fsm_pkg::*;
#(
  parameter int unsigned UART_BITS        = DEF_UART_BITS,
  parameter int unsigned INSTRUCTION_BITS = DEF_INSTRUCTION_BITS,
  parameter int unsigned PC_BITS          = DEF_PC_BITS
) (
  input logic               clk,
  input logic               rst,
  load_program_fsm_if.slave bus
);

  localparam logic [PC_BITS-1:0] ADDR_LAST = '1;

  state_e                      state_q, state_d;
  logic [PC_BITS-1:0]          addr_q, addr_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        overflow_q, overflow_d;

  logic                        accept_c;
  logic                        clear_c;
  logic                        halt_c;
  logic                        last_addr_c;
  logic                        word_valid;
  logic [INSTRUCTION_BITS-1:0] word;

  // Bytes only count while receiving; a start outside RECV discards any partial word
  assign accept_c    = bus.i_rx_done && (state_q == ST_RECV);
  assign clear_c     = bus.i_start && (state_q != ST_RECV);
  assign halt_c      = (word[INSTRUCTION_BITS-1 -: OPCODE_BITS] == HALT_OPCODE);
  assign last_addr_c = (addr_q == ADDR_LAST);

  load_program_fsm_word_assembler #(
    .UART_BITS        (UART_BITS),
    .INSTRUCTION_BITS (INSTRUCTION_BITS)
  ) u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_c),
    .byte_valid (accept_c),
    .byte_data  (bus.i_rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next state, write address and status flags
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          state_d    = ST_RECV;
          addr_d     = '0;
          overflow_d = 1'b0;
        end
      end
      ST_RECV: begin
        // word_valid marks the write cycle; the address moves on once it ends
        if (word_valid) begin
          if (!last_addr_c) begin
            addr_d = addr_q + PC_BITS'(1);
          end
          if (halt_c) begin
            state_d = ST_DONE;
          end else if (last_addr_c) begin
            state_d    = ST_DONE;
            overflow_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        addr_d     = '0;
        overflow_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_RECV);
    done_d = (state_d == ST_DONE);
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.o_inst_write   = word_valid;
  assign bus.o_inst_address = addr_q;
  assign bus.o_inst_data    = word;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_overflow     = overflow_q;

endmodule

// File: tb/tb_load_program_fsm.sv
// Directed bench for load_program_fsm: default-size instance A and a
// 4-word-memory instance B (PC_BITS=2) for the overflow boundary.
module tb_load_program_fsm;

  logic clk;
  logic rst;

  int tests = 0;
  int fails = 0;

  logic [63:0] wr_a[$];
  logic [63:0] wr_b[$];

  load_program_fsm_if                bus_a ();
  load_program_fsm_if #(.PC_BITS(2)) bus_b ();

  load_program_fsm dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  load_program_fsm #(.PC_BITS(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every memory write seen on either instance
  always @(negedge clk) begin
    if (bus_a.o_inst_write) wr_a.push_back({32'(bus_a.o_inst_address), bus_a.o_inst_data});
    if (bus_b.o_inst_write) wr_b.push_back({32'(bus_b.o_inst_address), bus_b.o_inst_data});
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit sel_b, input logic [7:0] b, input logic st);
    if (sel_b) begin
      bus_b.i_rx_done = 1'b1; bus_b.i_rx_data = b; bus_b.i_start = st;
    end else begin
      bus_a.i_rx_done = 1'b1; bus_a.i_rx_data = b; bus_a.i_start = st;
    end
    tick();
    bus_a.i_rx_done = 1'b0; bus_a.i_start = 1'b0;
    bus_b.i_rx_done = 1'b0; bus_b.i_start = 1'b0;
  endtask

  task automatic send_word(input bit sel_b, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(sel_b, w[i*8 +: 8], 1'b0);
  endtask

  task automatic pulse_start(input bit sel_b);
    if (sel_b) bus_b.i_start = 1'b1;
    else       bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    bus_b.i_start = 1'b0;
  endtask

  task automatic check_status(input bit sel_b, input string tag,
                              input logic busy, input logic done, input logic ovf);
    if (sel_b) begin
      check({tag, " busy"}, 64'(bus_b.o_busy), 64'(busy));
      check({tag, " done"}, 64'(bus_b.o_done), 64'(done));
      check({tag, " ovf"},  64'(bus_b.o_overflow), 64'(ovf));
    end else begin
      check({tag, " busy"}, 64'(bus_a.o_busy), 64'(busy));
      check({tag, " done"}, 64'(bus_a.o_done), 64'(done));
      check({tag, " ovf"},  64'(bus_a.o_overflow), 64'(ovf));
    end
  endtask

  task automatic check_write_now(input bit sel_b, input string tag,
                                 input logic [31:0] addr, input logic [31:0] data);
    if (sel_b) begin
      check({tag, " we"},   64'(bus_b.o_inst_write), 64'(1));
      check({tag, " addr"}, 64'(bus_b.o_inst_address), 64'(addr));
      check({tag, " data"}, 64'(bus_b.o_inst_data), 64'(data));
    end else begin
      check({tag, " we"},   64'(bus_a.o_inst_write), 64'(1));
      check({tag, " addr"}, 64'(bus_a.o_inst_address), 64'(addr));
      check({tag, " data"}, 64'(bus_a.o_inst_data), 64'(data));
    end
  endtask

  task automatic check_log(input bit sel_b, input string tag, input int idx,
                           input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] obs;
    obs = '1;
    if (sel_b) begin
      if (idx < wr_b.size()) obs = wr_b[idx];
    end else begin
      if (idx < wr_a.size()) obs = wr_a[idx];
    end
    check(tag, obs, {addr, data});
  endtask

  logic [7:0] seq3 [12];

  initial begin
    seq3 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'hFC, 8'h00, 8'h00, 8'h2A};
    rst = 1'b1;
    bus_a.i_start = 1'b0; bus_a.i_rx_done = 1'b0; bus_a.i_rx_data = '0;
    bus_b.i_start = 1'b0; bus_b.i_rx_done = 1'b0; bus_b.i_rx_data = '0;
    tick(); tick();
    @(negedge clk);
    check("reset we", 64'(bus_a.o_inst_write), 64'(0));
    check("reset addr", 64'(bus_a.o_inst_address), 64'(0));
    check_status(1'b0, "reset", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // Reset in the middle of a word
    pulse_start(1'b0);
    send_byte(1'b0, 8'hAA, 1'b0);
    send_byte(1'b0, 8'hBB, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst we", 64'(bus_a.o_inst_write), 64'(0));
    check("midrst data", 64'(bus_a.o_inst_data), 64'(0));
    check_status(1'b0, "midrst", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Bytes in IDLE are ignored; start with a coincident byte drops the byte
    send_byte(1'b0, 8'h11, 1'b0);
    send_byte(1'b0, 8'h22, 1'b0);
    @(negedge clk);
    check_status(1'b0, "idle bytes", 1'b0, 1'b0, 1'b0);
    send_byte(1'b0, 8'h99, 1'b1);
    @(negedge clk);
    check_status(1'b0, "started", 1'b1, 1'b0, 1'b0);

    // Three-word program ending in HALT; a start mid-word is ignored
    send_byte(1'b0, 8'h12, 1'b0);
    send_byte(1'b0, 8'h34, 1'b1);
    send_byte(1'b0, 8'h56, 1'b0);
    @(negedge clk);
    check("pre-last we", 64'(bus_a.o_inst_write), 64'(0));
    send_byte(1'b0, 8'h78, 1'b0);
    @(negedge clk);
    check_write_now(1'b0, "w0", 32'd0, 32'h12345678);
    send_word(1'b0, 32'h00000001);
    send_word(1'b0, 32'hFC000000);
    @(negedge clk);
    check_write_now(1'b0, "w2", 32'd2, 32'hFC000000);
    tick();
    @(negedge clk);
    check_status(1'b0, "halt done", 1'b0, 1'b1, 1'b0);
    check("t2 count", 64'(wr_a.size()), 64'(3));
    check_log(1'b0, "t2 log0", 0, 32'd0, 32'h12345678);
    check_log(1'b0, "t2 log1", 1, 32'd1, 32'h00000001);
    check_log(1'b0, "t2 log2", 2, 32'd2, 32'hFC000000);
    send_word(1'b0, 32'hDEADBEEF);
    tick(); tick();
    check("t2 extra", 64'(wr_a.size()), 64'(3));
    check_status(1'b0, "t2 held", 1'b0, 1'b1, 1'b0);

    // Reload from DONE with bytes arriving every cycle
    wr_a.delete();
    pulse_start(1'b0);
    @(negedge clk);
    check_status(1'b0, "reload", 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      bus_a.i_rx_done = 1'b1;
      bus_a.i_rx_data = seq3[i];
      tick();
    end
    bus_a.i_rx_done = 1'b0;
    @(negedge clk);
    check_write_now(1'b0, "b2b w2", 32'd2, 32'hFC00002A);
    tick();
    @(negedge clk);
    check_status(1'b0, "b2b done", 1'b0, 1'b1, 1'b0);
    check("b2b count", 64'(wr_a.size()), 64'(3));
    check_log(1'b0, "b2b log0", 0, 32'd0, 32'h01020304);
    check_log(1'b0, "b2b log1", 1, 32'd1, 32'h05060708);
    check_log(1'b0, "b2b log2", 2, 32'd2, 32'hFC00002A);

    // Small memory filled without HALT
    tick();
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) send_word(1'b1, {8'(i), 24'h102030});
    @(negedge clk);
    check_write_now(1'b1, "ovf w3", 32'd3, 32'h03102030);
    tick();
    @(negedge clk);
    check_status(1'b1, "ovf done", 1'b0, 1'b1, 1'b1);
    send_word(1'b1, 32'h04102030);
    tick(); tick();
    check("ovf count", 64'(wr_b.size()), 64'(4));
    for (int i = 0; i < 4; i++) check_log(1'b1, "ovf log", i, 32'(i), {8'(i), 24'h102030});

    // Restart from DONE clears flags; HALT exactly at the last address
    wr_b.delete();
    pulse_start(1'b1);
    @(negedge clk);
    check_status(1'b1, "restart", 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) send_word(1'b1, {8'(8'h20 + i), 24'hABCDEF});
    send_word(1'b1, 32'hFC123456);
    tick();
    @(negedge clk);
    check_status(1'b1, "halt last", 1'b0, 1'b1, 1'b0);
    check("halt last count", 64'(wr_b.size()), 64'(4));
    check_log(1'b1, "halt last log0", 0, 32'd0, 32'h20ABCDEF);
    check_log(1'b1, "halt last log3", 3, 32'd3, 32'hFC123456);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
